// File: rtl/apb_regbank_param.sv
// apb_regbank_param: parametrised APB3 register bank with system, config (RW) and status (RO) words.
// Optional macro APBRB_PSTRB_EN adds the PSTRB port and byte-lane write strobes.
module apb_regbank_param #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NUM_RW      = 5,
  parameter int unsigned NUM_RO      = 3,
  parameter int unsigned INTR_W      = 2,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] VERSION     = 32'h0002_0000
) (
  input  logic                  I_APBRB_PCLK,
  input  logic                  I_APBRB_PRESET_N,
  input  logic                  I_APBRB_PSEL,
  input  logic                  I_APBRB_PENABLE,
  input  logic                  I_APBRB_PWRITE,
  input  logic [ADDR_W-1:0]     I_APBRB_PADDR,
  input  logic [31:0]           I_APBRB_PWDATA,
`ifdef APBRB_PSTRB_EN
  input  logic [3:0]            I_APBRB_PSTRB,
`endif
  input  logic [NUM_RO*32-1:0]  I_APBRB_RO_REGS,
  input  logic [INTR_W-1:0]     I_APBRB_INTR_SET,
  output logic [31:0]           O_APBRB_PRDATA,
  output logic                  O_APBRB_PREADY,
  output logic                  O_APBRB_PSLVERR,
  output logic [NUM_RW*32-1:0]  O_APBRB_RW_REGS,
  output logic                  O_APBRB_START,
  output logic                  O_APBRB_SOFT_RST,
  output logic                  O_APBRB_IRQ
);

  localparam int unsigned NUM_WORDS = 4 + NUM_RW + NUM_RO;
  localparam int unsigned RO_BASE   = 4 + NUM_RW;

  if (NUM_WORDS > 2 ** (ADDR_W - 2)) begin : g_map_too_big
    $error("apb_regbank_param: register map does not fit in ADDR_W");
  end
  if (WAIT_STATES > 15 || INTR_W < 1 || INTR_W > 32) begin : g_bad_param
    $error("apb_regbank_param: WAIT_STATES or INTR_W out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                commit;
  logic                access;
  logic [31:0]         word_idx;
  logic                err;
  logic                wr_ok;
  logic [3:0]          strb;
  logic [31:0]         byte_mask;
  logic [31:0]         rdata;
  logic [NUM_RW*32-1:0] rw_flat;
  logic [INTR_W-1:0]   mask_q, mask_d;
  logic [INTR_W-1:0]   status_q, status_d;
  logic                ctrl_wr;
  logic [31:0]         prdata_q;
  logic                pready_q, pslverr_q, start_q, soft_rst_q, irq_q;

  assign access   = I_APBRB_PSEL & I_APBRB_PENABLE;
  assign word_idx = 32'(I_APBRB_PADDR >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        // Master dropping PSEL/PENABLE mid-wait abandons the access silently.
        if (!access) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef APBRB_PSTRB_EN
  assign strb = I_APBRB_PSTRB;
`else
  assign strb = 4'hF;
`endif

  always_comb begin
    err = (I_APBRB_PADDR[1:0] != 2'b00) || (word_idx >= NUM_WORDS) ||
          (I_APBRB_PWRITE && ((word_idx == 32'd3) || (word_idx >= RO_BASE)));
`ifdef APBRB_PSTRB_EN
    if (!I_APBRB_PWRITE && (I_APBRB_PSTRB != 4'h0)) err = 1'b1;
`endif
  end

  assign wr_ok   = commit & I_APBRB_PWRITE & ~err;
  assign ctrl_wr = wr_ok & (word_idx == 32'd0) & strb[0];

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < 4; b++) begin
      byte_mask[8*b +: 8] = {8{strb[b]}};
    end
  end

  always_comb begin
    rdata = '0;
    if (word_idx == 32'd1) rdata = 32'(mask_q);
    if (word_idx == 32'd2) rdata = 32'(status_q);
    if (word_idx == 32'd3) rdata = VERSION;
    for (int k = 0; k < NUM_RW; k++) begin
      if (word_idx == 32'(4 + k)) rdata = rw_flat[32*k +: 32];
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (word_idx == 32'(RO_BASE + k)) rdata = I_APBRB_RO_REGS[32*k +: 32];
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (wr_ok && word_idx == 32'd1) begin
      for (int i = 0; i < INTR_W; i++) begin
        mask_d[i] = byte_mask[i] ? I_APBRB_PWDATA[i] : mask_q[i];
      end
    end
    status_d = status_q;
    if (wr_ok && word_idx == 32'd2 && strb[0]) status_d = status_q & ~I_APBRB_PWDATA[INTR_W-1:0];
    if (ctrl_wr && I_APBRB_PWDATA[1]) status_d = '0;
    // A set pulse on the same edge as a clear always wins.
    status_d = status_d | I_APBRB_INTR_SET;
  end

  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw
    logic [31:0] rw_q;
    always_ff @(posedge I_APBRB_PCLK) begin
      if (!I_APBRB_PRESET_N) begin
        rw_q <= '0;
      end else if (wr_ok && word_idx == 32'(4 + gi)) begin
        rw_q <= (rw_q & ~byte_mask) | (I_APBRB_PWDATA & byte_mask);
      end
    end
    assign rw_flat[32*gi +: 32] = rw_q;
  end

  always_ff @(posedge I_APBRB_PCLK) begin
    if (!I_APBRB_PRESET_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      status_q   <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      start_q    <= 1'b0;
      soft_rst_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      status_q   <= status_d;
      pready_q   <= commit;
      start_q    <= ctrl_wr & I_APBRB_PWDATA[0];
      soft_rst_q <= ctrl_wr & I_APBRB_PWDATA[1];
      irq_q      <= |(status_q & ~mask_q);
      if (commit) begin
        pslverr_q <= err;
        if (!I_APBRB_PWRITE) prdata_q <= err ? 32'h0 : rdata;
      end
    end
  end

  assign O_APBRB_PRDATA   = prdata_q;
  assign O_APBRB_PREADY   = pready_q;
  assign O_APBRB_PSLVERR  = pslverr_q;
  assign O_APBRB_RW_REGS  = rw_flat;
  assign O_APBRB_START    = start_q;
  assign O_APBRB_SOFT_RST = soft_rst_q;
  assign O_APBRB_IRQ      = irq_q;

endmodule

// File: tb/tb_apb_regbank_param.sv
// tb_apb_regbank_param: directed plus randomized APB traffic checked against an array-based register model.
module tb_apb_regbank_param;

  localparam int AW  = 8;
  localparam int NRW = 5;
  localparam int NRO = 3;
  localparam int IW  = 2;
  localparam int WS  = 2;
  localparam logic [31:0] VER = 32'h0002_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, psel, penable, pwrite;
  logic [AW-1:0]      paddr;
  logic [31:0]        pwdata;
`ifdef APBRB_PSTRB_EN
  logic [3:0]         pstrb;
`endif
  logic [NRO*32-1:0]  ro_regs;
  logic [IW-1:0]      intr_set;
  logic [31:0]        prdata;
  logic               pready, pslverr, start, soft_rst, irq;
  logic [NRW*32-1:0]  rw_regs;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rw [NRW];
  logic [IW-1:0] m_mask, m_status;
  logic [31:0] m_prdata;

  apb_regbank_param #(
    .ADDR_W(AW), .NUM_RW(NRW), .NUM_RO(NRO), .INTR_W(IW), .WAIT_STATES(WS), .VERSION(VER)
  ) dut (
    .I_APBRB_PCLK(clk),
    .I_APBRB_PRESET_N(rst_n),
    .I_APBRB_PSEL(psel),
    .I_APBRB_PENABLE(penable),
    .I_APBRB_PWRITE(pwrite),
    .I_APBRB_PADDR(paddr),
    .I_APBRB_PWDATA(pwdata),
`ifdef APBRB_PSTRB_EN
    .I_APBRB_PSTRB(pstrb),
`endif
    .I_APBRB_RO_REGS(ro_regs),
    .I_APBRB_INTR_SET(intr_set),
    .O_APBRB_PRDATA(prdata),
    .O_APBRB_PREADY(pready),
    .O_APBRB_PSLVERR(pslverr),
    .O_APBRB_RW_REGS(rw_regs),
    .O_APBRB_START(start),
    .O_APBRB_SOFT_RST(soft_rst),
    .O_APBRB_IRQ(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < NRW; k++) m_rw[k] = '0;
    m_mask = '0;
    m_status = '0;
    m_prdata = '0;
  endtask

  function automatic bit m_err(input bit wr, input logic [7:0] a, input logic [3:0] s);
    int idx;
    bit e;
    idx = int'(a[7:2]);
    e = (a[1:0] != 2'b00) || (idx >= 4 + NRW + NRO) || (wr && (idx == 3 || idx >= 4 + NRW));
`ifdef APBRB_PSTRB_EN
    if (!wr && s != 4'h0) e = 1'b1;
`else
    if (s == 4'h0) e = e;
`endif
    return e;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int idx;
    idx = int'(a[7:2]);
    if (idx == 0) return 32'h0;
    if (idx == 1) return 32'(m_mask);
    if (idx == 2) return 32'(m_status);
    if (idx == 3) return VER;
    if (idx < 4 + NRW) return m_rw[idx-4];
    return ro_regs[32*(idx-4-NRW) +: 32];
  endfunction

  task automatic check_rw(input string tag);
    for (int k = 0; k < NRW; k++) chk({tag, " rw_reg"}, rw_regs[32*k +: 32], m_rw[k]);
  endtask

  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s_in, input logic [IW-1:0] iset, input string tag);
    logic [3:0]  s;
    logic [31:0] exp_rd, tmp;
    bit          exp_err, e_start, e_srst;
    int          lat, idx;
    logic        got_err, got_start, got_srst;
    logic [31:0] got_rd;
    s = s_in;
`ifndef APBRB_PSTRB_EN
    s = 4'hF;
`endif
    e_start = 1'b0;
    e_srst  = 1'b0;
    lat     = 0;
    idx     = int'(a[7:2]);
    exp_err = m_err(wr, a, s);
    exp_rd  = exp_err ? 32'h0 : m_read(a);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
`ifdef APBRB_PSTRB_EN
    pstrb = s;
`endif
    for (int c = 1; c <= WS + 8; c++) begin
      if (c > 1) @(negedge clk);
      penable  = 1'b1;
      intr_set = (c == WS + 1) ? iset : '0;
      if (c > 1 && pready) begin
        lat = c;
        break;
      end
    end
    got_err = pslverr; got_start = start; got_srst = soft_rst; got_rd = prdata;
    intr_set = '0; psel = 1'b0; penable = 1'b0;
    if (!wr) begin
      m_prdata = exp_rd;
    end else if (!exp_err) begin
      if (idx == 0) begin
        if (s[0]) begin
          e_start = d[0];
          e_srst  = d[1];
          if (d[1]) m_status = '0;
        end
      end else if (idx == 1) begin
        tmp = 32'(m_mask);
        for (int b = 0; b < 4; b++) if (s[b]) tmp[8*b +: 8] = d[8*b +: 8];
        m_mask = tmp[IW-1:0];
      end else if (idx == 2) begin
        if (s[0]) m_status = m_status & ~d[IW-1:0];
      end else begin
        for (int b = 0; b < 4; b++) if (s[b]) m_rw[idx-4][8*b +: 8] = d[8*b +: 8];
      end
    end
    m_status = m_status | iset;
    chk({tag, " latency"}, lat, WS + 2);
    chk({tag, " pslverr"}, got_err, exp_err);
    chk({tag, " prdata"}, got_rd, m_prdata);
    chk({tag, " start"}, got_start, e_start);
    chk({tag, " soft_rst"}, got_srst, e_srst);
    @(negedge clk);
    chk({tag, " pready_drop"}, pready, 1'b0);
    chk({tag, " start_drop"}, start, 1'b0);
    chk({tag, " soft_rst_drop"}, soft_rst, 1'b0);
    chk({tag, " irq"}, irq, |(m_status & ~m_mask));
    check_rw(tag);
    $display("txn %s wr=%0d addr=%02h wdata=%08h prdata=%08h pslverr=%0d lat=%0d",
             tag, wr, a, d, got_rd, got_err, lat);
  endtask

  task automatic pulse(input logic [IW-1:0] v);
    @(negedge clk); intr_set = v;
    @(negedge clk); intr_set = '0; m_status = m_status | v;
    @(negedge clk);
    chk("irq_after_set", irq, |(m_status & ~m_mask));
  endtask

  initial begin
    logic [3:0] s;
    int r;
    logic [7:0] a;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APBRB_PSTRB_EN
    pstrb = 4'h0;
`endif
    ro_regs = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    intr_set = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset prdata", prdata, 32'h0);
    chk("reset pready", pready, 1'b0);
    chk("reset pslverr", pslverr, 1'b0);
    chk("reset start", start, 1'b0);
    chk("reset soft_rst", soft_rst, 1'b0);
    chk("reset irq", irq, 1'b0);
    check_rw("reset");
    rst_n = 1'b1;

    // Version read with wait states, then basic RW and CTRL behaviour.
    apb(1'b0, 8'h0C, 32'h0, 4'h0, '0, "rd_version");
    chk("version value", prdata, 32'h0002_0000);
    apb(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, '0, "wr_rw0");
    apb(1'b0, 8'h10, 32'h0, 4'h0, '0, "rd_rw0");
    chk("rw0 value", rw_regs[31:0], 32'hDEADBEEF);
    apb(1'b1, 8'h00, 32'h1, 4'hF, '0, "wr_ctrl_start");
    apb(1'b0, 8'h00, 32'h0, 4'h0, '0, "rd_ctrl");
    apb(1'b1, 8'h00, 32'h3, 4'hF, '0, "wr_ctrl_both");

    // Interrupt set, W1C with simultaneous set, mask.
    pulse(2'b01);
    apb(1'b0, 8'h08, 32'h0, 4'h0, '0, "rd_status_set");
    apb(1'b1, 8'h08, 32'h1, 4'hF, 2'b01, "w1c_vs_set");
    apb(1'b0, 8'h08, 32'h0, 4'h0, '0, "rd_status_kept");
    apb(1'b1, 8'h08, 32'h1, 4'hF, '0, "w1c_clear");
    apb(1'b1, 8'h04, 32'h2, 4'hF, '0, "wr_mask");
    pulse(2'b10);
    apb(1'b0, 8'h04, 32'h0, 4'h0, '0, "rd_mask");
    apb(1'b1, 8'h00, 32'h2, 4'hF, '0, "soft_rst_clears");

    // Error responses.
    apb(1'b1, 8'h24, 32'h5555_AAAA, 4'hF, '0, "wr_ro");
    apb(1'b1, 8'hFC, 32'h5555_AAAA, 4'hF, '0, "wr_oob");
    apb(1'b1, 8'h11, 32'h5555_AAAA, 4'hF, '0, "wr_misalign");
    apb(1'b1, 8'h0C, 32'h5555_AAAA, 4'hF, '0, "wr_version");
    apb(1'b0, 8'hFC, 32'h0, 4'h0, '0, "rd_oob");
    apb(1'b0, 8'h24, 32'h0, 4'h0, '0, "rd_ro0");
    apb(1'b0, 8'h2C, 32'h0, 4'h0, '0, "rd_ro_last");
    apb(1'b0, 8'h30, 32'h0, 4'h0, '0, "rd_first_oob");

`ifdef APBRB_PSTRB_EN
    apb(1'b1, 8'h10, 32'h0, 4'hF, '0, "wr_rw0_zero");
    apb(1'b1, 8'h10, 32'hAABBCCDD, 4'b0010, '0, "wr_rw0_lane1");
    chk("pstrb lane1", rw_regs[31:0], 32'h0000CC00);
    apb(1'b0, 8'h10, 32'h0, 4'h1, '0, "rd_with_strb");
`endif

    // Protocol abort during WAIT: no commit and no PREADY.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'h1234_5678;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort pready", pready, 1'b0);
    end
    check_rw("abort");

    // Reset asserted mid-transfer.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h18; pwdata = 32'hCAFE_F00D;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst pready", pready, 1'b0);
    end
    chk("midrst prdata", prdata, 32'h0);
    chk("midrst irq", irq, 1'b0);
    check_rw("midrst");
    rst_n = 1'b1;

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      @(negedge clk);
      ro_regs = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) pulse(IW'($urandom));
      r = $urandom_range(0, 9);
      a = (r < 7) ? 8'($urandom_range(0, 13) * 4) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        s = 4'($urandom);
        apb(1'b1, a, $urandom, s, ($urandom_range(0, 3) == 0) ? IW'($urandom) : '0, "rnd_wr");
      end else begin
        s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
        apb(1'b0, a, 32'h0, s, ($urandom_range(0, 3) == 0) ? IW'($urandom) : '0, "rnd_rd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
